// File: rtl/writeback_merge_stage.sv
// Writeback merge: selects one of buffer head / load / ALU per cycle onto a registered
// register-file write port; losers queue in order. Optional forwarding search: WB_FORWARD_EN.
module writeback_merge_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  input  logic [ADDR_W-1:0]          load_addr,
  output logic                       stall_out,
  output logic [DATA_W-1:0]          write_data,
  output logic [ADDR_W-1:0]          reg_addr_out,
  output logic                       write_enable_out,
  output logic [$clog2(DEPTH):0]     pend_count,
  output logic                       overflow_err
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0]          fwd_addr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               we_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic               ovf_q, ovf_d;

  entry_t             load_e, alu_e, head_e;
  entry_t             arr0_e, cand0_e, cand1_e, sel_e;
  logic               arr0_v, arr1_v, cand0_v, cand1_v, sel_v;
  logic               has_head, push0, push1;
  logic [CNT_W-1:0]   free_slots;
  logic [PTR_W-1:0]   wr_ptr_p1;

  assign load_e    = '{addr: load_addr, data: load_data};
  assign alu_e     = '{addr: alu_addr,  data: alu_data};
  assign head_e    = mem_q[rd_ptr_q];
  assign has_head  = (count_q != '0);
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

  // Arrivals compacted so arr0 is always the older one (load before ALU).
  assign arr0_v = load_valid | alu_valid;
  assign arr0_e = load_valid ? load_e : alu_e;
  assign arr1_v = load_valid & alu_valid;

  always_comb begin
    sel_v   = 1'b0;
    sel_e   = head_e;
    cand0_v = 1'b0;
    cand0_e = arr0_e;
    cand1_v = 1'b0;
    cand1_e = alu_e;
    if (has_head) begin
      sel_v   = 1'b1;
      cand0_v = arr0_v;
      cand1_v = arr1_v;
    end else begin
      sel_v   = arr0_v;
      sel_e   = arr0_e;
      cand0_v = arr1_v;
      cand0_e = alu_e;
    end
  end

  // Space is counted after this cycle's pop, so a full buffer still takes one push.
  assign free_slots = CNT_W'(DEPTH) - count_q + CNT_W'(has_head);
  assign push0      = cand0_v && (free_slots >= CNT_W'(1));
  assign push1      = cand1_v && (free_slots >= CNT_W'(2));

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(has_head);
    wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
    count_d  = count_q - CNT_W'(has_head) + CNT_W'(push0) + CNT_W'(push1);
    ovf_d    = ovf_q | (cand0_v & ~push0) | (cand1_v & ~push1);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push0 && wr_ptr_q == PTR_W'(gi)) begin
          mem_q[gi] <= cand0_e;
        end else if (push1 && wr_ptr_p1 == PTR_W'(gi)) begin
          mem_q[gi] <= cand1_e;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      waddr_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      we_q     <= sel_v;
      if (sel_v) begin
        wdata_q <= sel_e.data;
        waddr_q <= sel_e.addr;
      end
    end
  end

  assign write_enable_out = we_q;
  assign write_data       = wdata_q;
  assign reg_addr_out     = waddr_q;
  assign pend_count       = count_q;
  assign overflow_err     = ovf_q;
  assign stall_out        = (count_q > CNT_W'(DEPTH - 2));

`ifdef WB_FORWARD_EN
  // Later matches overwrite earlier ones, so the search runs oldest to newest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = rd_ptr_q;
    if (we_q && waddr_q == fwd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = wdata_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && mem_q[idx].addr == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_q[idx].data;
      end
    end
    if (load_valid && load_addr == fwd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = load_data;
    end
    if (alu_valid && alu_addr == fwd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = alu_data;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_merge_stage.sv
// Bench for writeback_merge_stage: directed test-plan steps then random traffic,
// each cycle compared against a queue-based reference model.
module tb_writeback_merge_stage;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid, load_valid;
  logic [DATA_W-1:0] alu_data, load_data;
  logic [ADDR_W-1:0] alu_addr, load_addr;
  logic              stall_out, write_enable_out, overflow_err;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] reg_addr_out;
  logic [$clog2(DEPTH):0] pend_count;
`ifdef WB_FORWARD_EN
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  writeback_merge_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_valid        (alu_valid),
    .alu_data         (alu_data),
    .alu_addr         (alu_addr),
    .load_valid       (load_valid),
    .load_data        (load_data),
    .load_addr        (load_addr),
    .stall_out        (stall_out),
    .write_data       (write_data),
    .reg_addr_out     (reg_addr_out),
    .write_enable_out (write_enable_out),
    .pend_count       (pend_count),
    .overflow_err     (overflow_err)
`ifdef WB_FORWARD_EN
    ,
    .fwd_addr         (fwd_addr),
    .fwd_hit          (fwd_hit),
    .fwd_data         (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
  } ent_t;

  ent_t              q[$];
  logic              m_we, m_ovf;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".we"},    32'(write_enable_out), 32'(m_we));
    chk({tag, ".data"},  32'(write_data),       32'(m_data));
    chk({tag, ".addr"},  32'(reg_addr_out),     32'(m_addr));
    chk({tag, ".pend"},  32'(pend_count),       32'(q.size()));
    chk({tag, ".stall"}, 32'(stall_out),        32'(q.size() > DEPTH - 2));
    chk({tag, ".ovf"},   32'(overflow_err),     32'(m_ovf));
  endtask

`ifdef WB_FORWARD_EN
  task automatic check_forward(input string tag);
    logic              hit;
    logic [DATA_W-1:0] val;
    hit = 1'b0;
    val = '0;
    if (m_we && m_addr == fwd_addr) begin hit = 1'b1; val = m_data; end
    foreach (q[i]) if (q[i].a == fwd_addr) begin hit = 1'b1; val = q[i].d; end
    if (load_valid && load_addr == fwd_addr) begin hit = 1'b1; val = load_data; end
    if (alu_valid && alu_addr == fwd_addr) begin hit = 1'b1; val = alu_data; end
    chk({tag, ".fwd_hit"}, 32'(fwd_hit), 32'(hit));
    if (hit) chk({tag, ".fwd_data"}, 32'(fwd_data), 32'(val));
  endtask
`endif

  // Reference: oldest pending wins, else load, else ALU; leftovers queue if room.
  task automatic model_step();
    ent_t arr[$];
    ent_t e;
    if (load_valid) begin e.d = load_data; e.a = load_addr; arr.push_back(e); end
    if (alu_valid)  begin e.d = alu_data;  e.a = alu_addr;  arr.push_back(e); end
    if (q.size() > 0) begin
      e = q.pop_front(); m_we = 1'b1; m_data = e.d; m_addr = e.a;
    end else if (arr.size() > 0) begin
      e = arr.pop_front(); m_we = 1'b1; m_data = e.d; m_addr = e.a;
    end else begin
      m_we = 1'b0;
    end
    foreach (arr[i]) begin
      if (q.size() < DEPTH) q.push_back(arr[i]);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step(input string tag,
                      input logic lv, input logic [DATA_W-1:0] ld, input logic [ADDR_W-1:0] la,
                      input logic av, input logic [DATA_W-1:0] ad, input logic [ADDR_W-1:0] aa);
    @(negedge clk);
    rst_n = 1'b1;
    load_valid = lv; load_data = ld; load_addr = la;
    alu_valid  = av; alu_data  = ad; alu_addr  = aa;
`ifdef WB_FORWARD_EN
    fwd_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
    #1 check_forward(tag);
`endif
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
    $display("cycle %s lv=%0b ld=%h la=%h av=%0b ad=%h aa=%h -> we=%0b wd=%h wa=%h pend=%0d stall=%0b ovf=%0b",
             tag, lv, ld, la, av, ad, aa, write_enable_out, write_data, reg_addr_out,
             pend_count, stall_out, overflow_err);
  endtask

  task automatic reset_step(input string tag);
    @(negedge clk);
    rst_n      = 1'b0;
    load_valid = 1'b1; load_data = 8'hEE; load_addr = 4'hE;
    alu_valid  = 1'b1; alu_data  = 8'hDD; alu_addr  = 4'hD;
    q.delete();
    m_we = 1'b0; m_data = '0; m_addr = '0; m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check_outputs(tag);
    $display("cycle %s reset -> we=%0b pend=%0d stall=%0b ovf=%0b",
             tag, write_enable_out, pend_count, stall_out, overflow_err);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0; load_data = '0; load_addr = '0;
    alu_valid  = 1'b0; alu_data  = '0; alu_addr  = '0;
`ifdef WB_FORWARD_EN
    fwd_addr = '0;
`endif
    reset_step("rst0");
    reset_step("rst1");
    chk("rst.we", 32'(write_enable_out), 32'd0);
    chk("rst.pend", 32'(pend_count), 32'd0);

    // Single ALU result bypasses the empty buffer.
    step("alu_only", 1'b0, 8'h00, 4'h0, 1'b1, 8'hAA, 4'h3);
    chk("alu_only.data_const", 32'(write_data), 32'hAA);
    chk("alu_only.pend_const", 32'(pend_count), 32'd0);
    idle("idle", 1);

    // Collision: load first, ALU one cycle later.
    step("coll0", 1'b1, 8'h11, 4'h5, 1'b1, 8'h22, 4'h6);
    chk("coll0.addr_const", 32'(reg_addr_out), 32'h5);
    chk("coll0.pend_const", 32'(pend_count), 32'd1);
    step("coll1", 1'b0, 8'h00, 4'h0, 1'b0, 8'h00, 4'h0);
    chk("coll1.data_const", 32'(write_data), 32'h22);
    chk("coll1.pend_const", 32'(pend_count), 32'd0);

    // Three dual cycles: fills to DEPTH-1 and stalls, no overflow.
    for (int i = 0; i < 3; i++)
      step("dual3", 1'b1, 8'(8'h30 + i), 4'(i), 1'b1, 8'(8'h40 + i), 4'(i + 8));
    chk("dual3.stall_const", 32'(stall_out), 32'd1);
    chk("dual3.ovf_const", 32'(overflow_err), 32'd0);
    idle("drain3", 4);

    // Five dual cycles ignoring stall: the last ALU result is dropped.
    for (int i = 0; i < 5; i++)
      step("dual5", 1'b1, 8'(8'h50 + i), 4'(i), 1'b1, 8'(8'h60 + i), 4'(i + 8));
    chk("dual5.ovf_const", 32'(overflow_err), 32'd1);
    chk("dual5.pend_const", 32'(pend_count), 32'd4);
    idle("drain5", 5);

    // Reset with two pending entries discards them.
    reset_step("rst_ovf");
    step("pre2a", 1'b1, 8'h71, 4'h1, 1'b1, 8'h72, 4'h2);
    step("pre2b", 1'b1, 8'h73, 4'h3, 1'b1, 8'h74, 4'h4);
    chk("pre2.pend_const", 32'(pend_count), 32'd2);
    reset_step("rst_mid");
    chk("rst_mid.pend_const", 32'(pend_count), 32'd0);
    idle("post_rst", 2);
    chk("post_rst.we_const", 32'(write_enable_out), 32'd0);

`ifdef WB_FORWARD_EN
    step("fwd_setup", 1'b1, 8'h01, 4'h1, 1'b1, 8'h33, 4'h7);
    @(negedge clk);
    load_valid = 1'b1; load_data = 8'h44; load_addr = 4'h7;
    alu_valid = 1'b0;
    fwd_addr = 4'h7;
    #1;
    chk("fwd7.hit", 32'(fwd_hit), 32'd1);
    chk("fwd7.data", 32'(fwd_data), 32'h44);
    fwd_addr = 4'h9;
    #1;
    chk("fwd9.hit", 32'(fwd_hit), 32'd0);
    step("fwd_after", 1'b1, 8'h44, 4'h7, 1'b0, 8'h00, 4'h0);
    idle("fwd_drain", 3);
`endif

    // Random traffic; half the time upstream honours stall.
    for (int i = 0; i < 400; i++) begin
      logic honour, lv, av;
      honour = (i / 100) % 2 == 0;
      lv = ($urandom_range(0, 99) < 55);
      av = ($urandom_range(0, 99) < 55);
      if (honour && stall_out) begin lv = 1'b0; av = 1'b0; end
      if ($urandom_range(0, 79) == 0) reset_step("rnd_rst");
      else step("rnd", lv, 8'($urandom), 4'($urandom), av, 8'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
